gpio_input_conditioner: RTL and testbench

//  Front end for all raw GPIO_1 inputs: photoresistor sensors A[1:0] and B[1:0], and the CLK/RESET push-buttons.

---
 rtl/gpio_cond_pkg.sv | 24 ++
 rtl/debounce_channel.sv | 104 ++++++++++
 rtl/gpio_input_conditioner.sv | 60 ++++++
 tb/tb_gpio_input_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cond_pkg.sv
// rtl/gpio_cond_pkg.sv - shared types, bit indices and helpers for the GPIO input conditioner
package gpio_cond_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } deb_state_t;

    // Bit positions of each raw input on gpio_in
    localparam int IDX_A0  = 0;
    localparam int IDX_A1  = 1;
    localparam int IDX_B0  = 2;
    localparam int IDX_B1  = 3;
    localparam int IDX_CLK = 4;
    localparam int IDX_RST = 5;

    // Counter must hold values up to DEBOUNCE_CYCLES without wrapping
    function automatic int cnt_width(input int debounce_cycles);
        return (debounce_cycles < 1) ? 1 : $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchroniser plus four-state debouncer for one raw input
import gpio_cond_pkg::*;

module debounce_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int                CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_t             state;
    logic [CW-1:0]          cnt;

    assign s = sync_q[SYNC_STAGES-1];

    // Plain flop chain bringing the asynchronous pin into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Debounce FSM: a level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= STABLE_HI;
                            level <= 1'b1;
                            rise  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            state <= PEND_HI;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                PEND_HI: begin
                    if (!s) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HI;
                        level <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= STABLE_LO;
                            level <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            state <= PEND_LO;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                PEND_LO: begin
                    if (s) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        level <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - conditions raw GPIO sensor and button inputs into clean levels and pulses
import gpio_cond_pkg::*;

module gpio_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int N_IN            = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] gpio_in,
    output logic [1:0]      a_level,
    output logic [1:0]      b_level,
    output logic            btn_clk_level,
    output logic            btn_clk_pulse,
    output logic            btn_rst_level,
    output logic            btn_rst_pulse,
    output logic            change_evt
);

    logic [N_IN-1:0] lvl;
    logic [N_IN-1:0] rise;
    logic [3:0]      sens_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_chan
            debounce_channel #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_chan (
                .clk   (clk),
                .rst   (rst),
                .din   (gpio_in[gi]),
                .level (lvl[gi]),
                .rise  (rise[gi])
            );
        end
    endgenerate

    assign a_level       = {lvl[IDX_A1], lvl[IDX_A0]};
    assign b_level       = {lvl[IDX_B1], lvl[IDX_B0]};
    assign btn_clk_level = lvl[IDX_CLK];
    assign btn_clk_pulse = rise[IDX_CLK];
    assign btn_rst_level = lvl[IDX_RST];
    assign btn_rst_pulse = rise[IDX_RST];

    // One-cycle-delayed copy of the sensor levels; XOR against it marks the edge a level moved
    always_ff @(posedge clk) begin
        if (rst) begin
            sens_q <= '0;
        end else begin
            sens_q <= lvl[IDX_B1:IDX_A0];
        end
    end

    // Both operands are flops, so the OR-reduction is glitch-free and merges simultaneous changes
    assign change_evt = |(lvl[IDX_B1:IDX_A0] ^ sens_q);

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb/tb_gpio_input_conditioner.sv - randomized and directed self-checking bench for gpio_input_conditioner
module tb_gpio_input_conditioner;

    localparam int S = 2;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] gpio_in = 6'h00;
    logic [1:0] a_level, b_level;
    logic       btn_clk_level, btn_clk_pulse, btn_rst_level, btn_rst_pulse, change_evt;

    int checks = 0;
    int failures = 0;

    gpio_input_conditioner #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .N_IN            (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .gpio_in       (gpio_in),
        .a_level       (a_level),
        .b_level       (b_level),
        .btn_clk_level (btn_clk_level),
        .btn_clk_pulse (btn_clk_pulse),
        .btn_rst_level (btn_rst_level),
        .btn_rst_pulse (btn_rst_pulse),
        .change_evt    (change_evt)
    );

    always #10 clk = ~clk;

    // Reference model: delayed sample history plus run lengths of disagreeing samples
    logic [5:0] m_hist [S];
    int         m_run  [6];
    logic [5:0] m_lvl;
    logic [5:0] m_old;
    logic [5:0] m_s;
    logic       m_pclk, m_prst, m_chg;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < S; k++) m_hist[k] = '0;
            for (int i = 0; i < 6; i++) m_run[i] = 0;
            m_lvl  = '0;
            m_pclk = 1'b0;
            m_prst = 1'b0;
            m_chg  = 1'b0;
        end else begin
            m_s   = m_hist[S-1];
            m_old = m_lvl;
            for (int i = 0; i < 6; i++) begin
                if (m_s[i] != m_lvl[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= D) begin
                        m_lvl[i] = m_s[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pclk = !m_old[4] && m_lvl[4];
            m_prst = !m_old[5] && m_lvl[5];
            m_chg  = (m_old[3:0] != m_lvl[3:0]);
            for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = gpio_in;
        end
    end

    wire [8:0] dut_vec = {change_evt, btn_rst_pulse, btn_rst_level, btn_clk_pulse,
                          btn_clk_level, b_level, a_level};
    wire [8:0] mdl_vec = {m_chg, m_prst, m_lvl[5], m_pclk, m_lvl[4], m_lvl[3:2], m_lvl[1:0]};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gpio_in = 6'h3F;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (dut_vec !== 9'h000) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d got=%h want=000", c, dut_vec);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dut_vec !== 9'h000) begin
            failures++;
            $display("FAIL reset_release got=%h want=000", dut_vec);
        end
        gpio_in = 6'h00;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL reset_settle cycle=%0d got=%h want=%h", c, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        gpio_in[4] = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (btn_clk_pulse === 1'b1) pulses++;
            checks++;
            if (btn_clk_level !== (e >= 10) || btn_clk_pulse !== (e == 10)) begin
                failures++;
                $display("FAIL clean_press edge=%0d got lvl=%b pulse=%b want lvl=%b pulse=%b",
                         e, btn_clk_level, btn_clk_pulse, (e >= 10), (e == 10));
            end
            checks++;
            if (dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL clean_press_model edge=%0d got=%h want=%h", e, dut_vec, mdl_vec);
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL clean_press_count got=%0d want=1", pulses);
        end
        gpio_in[4] = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            checks++;
            if (btn_clk_pulse !== 1'b0 || dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL release_no_pulse cycle=%0d got=%h want=%h", c, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_glitch();
        gpio_in[0] = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            if (e == 8) gpio_in[0] = 1'b0;
            tick();
            checks++;
            if (a_level !== 2'b00 || change_evt !== 1'b0) begin
                failures++;
                $display("FAIL glitch edge=%0d got a=%b chg=%b want a=00 chg=0", e, a_level, change_evt);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat = 5'b01101;
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            gpio_in[5] = pat[i];
            tick();
            if (btn_rst_pulse === 1'b1) pulses++;
        end
        gpio_in[5] = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (btn_rst_pulse === 1'b1) pulses++;
            checks++;
            if (btn_rst_pulse !== (e == 10) || dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL bounce edge=%0d got pulse=%b want=%b vec=%h model=%h",
                         e, btn_rst_pulse, (e == 10), dut_vec, mdl_vec);
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL bounce_count got=%0d want=1", pulses);
        end
        gpio_in[5] = 1'b0;
        for (int c = 0; c < 14; c++) tick();
    endtask

    task automatic test_simultaneous();
        int chg = 0;
        gpio_in[3:0] = 4'b1011;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (change_evt === 1'b1) chg++;
            checks++;
            if (a_level !== ((e >= 10) ? 2'b11 : 2'b00) ||
                b_level !== ((e >= 10) ? 2'b10 : 2'b00) ||
                change_evt !== (e == 10)) begin
                failures++;
                $display("FAIL simultaneous edge=%0d got a=%b b=%b chg=%b", e, a_level, b_level, change_evt);
            end
        end
        checks++;
        if (chg != 1) begin
            failures++;
            $display("FAIL simultaneous_count got=%0d want=1", chg);
        end
        gpio_in = 6'h00;
        for (int c = 0; c < 14; c++) tick();
    endtask

    task automatic test_reset_mid();
        gpio_in[2] = 1'b1;
        for (int e = 1; e <= 7; e++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            checks++;
            if (b_level[0] !== (e >= 10) || dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL reset_mid edge=%0d got b0=%b want=%b vec=%h model=%h",
                         e, b_level[0], (e >= 10), dut_vec, mdl_vec);
            end
        end
        gpio_in = 6'h00;
        for (int c = 0; c < 14; c++) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 9) == 0) gpio_in[i] = ~gpio_in[i];
            end
            tick();
            checks++;
            if (dut_vec !== mdl_vec) begin
                failures++;
                $display("FAIL random cycle=%0d got=%h want=%h", c, dut_vec, mdl_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
